// File: rtl/pd_trace_pkg.sv
// pd_trace_pkg: shared types for the pd5 commit-trace path.
//   REG_ADDR_W  - architectural register index width
//   SEQ_W       - retire sequence number width
//   TRACE_XLEN  - PC/data width of a stored trace record
//   trace_rec_t - one retire record as held in the trace FIFO
package pd_trace_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int SEQ_W      = 32;
  localparam int TRACE_XLEN = 32;

  typedef struct packed {
    logic [SEQ_W-1:0]      seq;
    logic [TRACE_XLEN-1:0] pc;
    logic                  enable;
    logic [REG_ADDR_W-1:0] destination;
    logic [TRACE_XLEN-1:0] data;
  } trace_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO of trace_rec_t.
// The head entry is presented on o_data whenever o_empty is low; a pop
// advances to the next entry at the clock edge. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
//   clk, rst_n       - clock, asynchronous active-low reset
//   i_push, i_data   - write request and record
//   i_pop            - consume head entry (ignored while empty)
//   o_data           - head record (show-ahead)
//   o_count          - occupancy, 0..DEPTH
//   o_full, o_empty  - occupancy flags
module sync_fifo
  import pd_trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  trace_rec_t       i_data,
  input  logic             i_pop,
  output trace_rec_t       o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  trace_rec_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are meaningful, so resetting the RAM would only cost flops.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits and wrap naturally.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: commit-trace buffer at the tail of the pd5 pipeline.
// Each writeback-stage retire (w_valid) becomes a record tagged with a
// running 32-bit sequence number and is queued in a show-ahead FIFO that
// the trace consumer drains over tr_valid/tr_ready. The core is never
// stalled: a retire arriving while the FIFO is full and not popping is
// dropped, counted (saturating) and flagged in the sticky overflow bit.
//   clk, reset              - clock, asynchronous active-low reset
//   w_valid/pc/enable/
//   w_destination/w_data    - retire event from writeback
//   tr_valid, tr_ready      - trace stream handshake
//   tr_seq/pc/enable/
//   tr_destination/tr_data  - head record, zero while tr_valid is low
//   count                   - FIFO occupancy
//   overflow, drop_count    - drop status
//   clear                   - synchronous clear of overflow/drop_count
module wb_trace_buffer
  import pd_trace_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int XLEN   = 32,
  parameter  int DROP_W = 16,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w_valid,
  input  logic [XLEN-1:0]       w_pc,
  input  logic                  w_enable,
  input  logic [REG_ADDR_W-1:0] w_destination,
  input  logic [XLEN-1:0]       w_data,
  output logic                  tr_valid,
  input  logic                  tr_ready,
  output logic [SEQ_W-1:0]      tr_seq,
  output logic [XLEN-1:0]       tr_pc,
  output logic                  tr_enable,
  output logic [REG_ADDR_W-1:0] tr_destination,
  output logic [XLEN-1:0]       tr_data,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_count,
  input  logic                  clear
);

  logic [SEQ_W-1:0]  r_seq;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;

  trace_rec_t        w_rec;
  trace_rec_t        w_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_overflow_nxt;
  logic [DROP_W-1:0] w_drop_count_nxt;

  // Writes to x0 are architecturally invisible, so the record reports
  // them as "no write" with zero data regardless of what the core drove.
  always_comb begin
    w_rec             = '0;
    w_rec.seq         = r_seq;
    w_rec.pc          = TRACE_XLEN'(w_pc);
    w_rec.destination = w_destination;
    if (w_destination != '0) begin
      w_rec.enable = w_enable;
      w_rec.data   = TRACE_XLEN'(w_data);
    end
  end

  // tr_valid comes only from the registered occupancy, so there is no
  // combinational path from w_* or tr_ready to the stream valid.
  assign tr_valid = !w_fifo_empty;
  assign w_pop    = tr_valid && tr_ready;
  assign w_push   = w_valid && (!w_fifo_full || w_pop);
  assign w_drop   = w_valid && w_fifo_full && !w_pop;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // A drop in the same cycle as clear wins: the flag stays set and the
  // counter restarts at one, so that drop is never lost.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_overflow_nxt   = r_overflow;
    w_drop_count_nxt = r_drop_count;
    if (w_drop) begin
      w_overflow_nxt = 1'b1;
      if (clear) begin
        w_drop_count_nxt = DROP_W'(1);
      end else if (!(&r_drop_count)) begin
        w_drop_count_nxt = r_drop_count + DROP_W'(1);
      end
    end else if (clear) begin
      w_overflow_nxt   = 1'b0;
      w_drop_count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seq        <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      // Sequence advances on every retire, accepted or dropped, so gaps
      // in tr_seq reveal exactly which records were lost.
      if (w_valid) r_seq <= r_seq + SEQ_W'(1);
      r_overflow   <= w_overflow_nxt;
      r_drop_count <= w_drop_count_nxt;
    end
  end

  // Payload is forced to zero when no record is presented; the FIFO
  // head may hold stale or never-written storage in that case.
  assign tr_seq         = tr_valid ? w_head.seq : '0;
  assign tr_pc          = tr_valid ? XLEN'(w_head.pc) : '0;
  assign tr_enable      = tr_valid ? w_head.enable : 1'b0;
  assign tr_destination = tr_valid ? w_head.destination : '0;
  assign tr_data        = tr_valid ? XLEN'(w_head.data) : '0;

  assign count      = w_fifo_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Commit-trace buffer at the tail of the pd5 pipeline. Captures one retire record per writeback-stage event (PC, write-enable, destination, data), tags it with a running sequence number, and queues it in a show-ahead FIFO drained over a valid/ready stream by the trace consumer. Overflow never stalls the core: excess records are dropped, counted, and flagged.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `XLEN`, 32: PC/data width.
- `DROP_W`, 16: drop counter width.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `w_valid`  in  1  one instruction retires this cycle.
- `w_pc`  in  XLEN  retiring PC.
- `w_enable`  in  1  register write enable.
- `w_destination`  in  5  destination register.
- `w_data`  in  XLEN  writeback data.
- `tr_valid`  out  1  head record available.
- `tr_ready`  in  1  consumer accepts head.
- `tr_seq`  out  32  retire sequence number of head.
- `tr_pc`  out  XLEN  head PC.
- `tr_enable`  out  1  head write enable.
- `tr_destination`  out  5  head destination.
- `tr_data`  out  XLEN  head data.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `overflow`  out  1  sticky: at least one record dropped.
- `drop_count`  out  DROP_W  dropped records, saturating.
- `clear`  in  1  synchronous clear of `overflow` and `drop_count`.

## Operation
- Record formed from `w_*` when `w_valid`=1: seq = current seq counter; if `w_destination`==0, stored enable=0 and data=0 (x0 semantics); else fields stored verbatim.
- Seq counter: 32 bit, +1 on every `w_valid` (accepted or dropped), wraps 0xFFFFFFFF→0. Gaps in `tr_seq` expose drops.
- Pop = `tr_valid && tr_ready`. Push = `w_valid && (count<DEPTH || pop)`.
- Drop = `w_valid && count==DEPTH && !pop`: record discarded, `overflow`←1, `drop_count`+1 saturating at all-ones.
- Full with simultaneous push and pop: both occur, `count` unchanged, no drop.
- Empty with push: no bypass; record visible next cycle.
- `tr_ready` while empty: ignored, no state change.
- `clear`: `overflow`←0, `drop_count`←0; clear and drop in same cycle → `overflow`=1, `drop_count`=1. `clear` does not flush FIFO or seq counter.
- Pointers: log2(DEPTH) bits, natural wrap; `count` tracked separately.

## Timing
- Reset (async assert, any cycle including mid-drain): `count`=0, pointers=0, seq=0, `overflow`=0, `drop_count`=0, `tr_valid`=0. Storage array not reset.
- `tr_valid` = (`count`≠0), registered state only, no combinational path from `w_*` or `tr_ready`.
- All `tr_*` payload outputs forced to 0 when `tr_valid`=0; valid-to-payload consistent in same cycle.
- Latency: push at edge k → `tr_valid`=1 with that record at head after edge k (if ahead of queue).
- Payload stable while `tr_valid && !tr_ready`.
- Throughput: one push and one pop per cycle.

## Structure
- Package `pd_trace_pkg`: `REG_ADDR_W`=5, `SEQ_W`=32, typedef struct `trace_rec_t` {seq, pc, enable, destination, data}.
- Sub-module `sync_fifo` (generic show-ahead FIFO on `trace_rec_t`, push/pop/count/full/empty); `wb_trace_buffer` adds record formation, seq counter, drop logic, output gating.

## Test plan
- Reset, then `w_valid` with pc=0x1000, dest=5, data=0xDEADBEEF, enable=1 → next cycle `tr_valid`=1, seq=0, pc=0x1000, dest=5, data=0xDEADBEEF; `tr_ready`=1 → `count`=0, outputs zero.
- Retire with dest=0, data=0x1234, enable=1 → `tr_enable`=0, `tr_data`=0, `tr_destination`=0.
- `tr_ready`=0, 10 consecutive retires, DEPTH=8 → `count`=8, `overflow`=1, `drop_count`=2; drain → seq 0..7 in order; next retire seq=10.
- Full FIFO, `w_valid`=1 and `tr_ready`=1 same cycle → `count` stays 8, `drop_count` unchanged, tail holds new record.
- `clear` together with a drop → `overflow`=1, `drop_count`=1; `clear` alone next cycle → both 0, `count` unchanged.
- Assert `reset` low mid-drain with `count`=5 → `tr_valid`=0, `count`=0 immediately; after release first retire gets seq=0.
